ahb_lite_mem_slave: RTL and testbench

//  AHB-Lite slave: 32-bit word-addressed RAM, the responder side of the AHB-Lite master task bench.

---
 rtl/ahb_lite_defs.sv | 53 +++++
 rtl/ahb_lite_sram.sv | 25 ++
 rtl/ahb_lite_mem_slave.sv | 146 ++++++++++++++
 tb/tb_ahb_lite_mem_slave.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_defs.sv
// Shared AHB-Lite definitions: transfer/size/burst encodings, response and
// direction constants, slave FSM state encodings, byte-lane decode helper.
// Build option: AHB_LITE_SLAVE_ERROR_EN adds the ERR1/ERR2 response states.
package ahb_lite_defs;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    localparam logic HRESP_OKAY   = 1'b0;
    localparam logic HRESP_ERROR  = 1'b1;
    localparam logic HWRITE_READ  = 1'b0;
    localparam logic HWRITE_WRITE = 1'b1;

    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
    localparam logic [ST_W-1:0] ST_WAIT = 3'd1;
    localparam logic [ST_W-1:0] ST_DONE = 3'd2;
`ifdef AHB_LITE_SLAVE_ERROR_EN
    localparam logic [ST_W-1:0] ST_ERR1 = 3'd3;
    localparam logic [ST_W-1:0] ST_ERR2 = 3'd4;
`endif

    // Byte-lane enables; misaligned low bits are ignored, sizes above WORD act as WORD.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] m;
        m = 4'b1111;
        if (size == HSIZE_BYTE)      m = 4'b0001 << addr_lo;
        else if (size == HSIZE_HALF) m = addr_lo[1] ? 4'b1100 : 4'b0011;
        return m;
    endfunction

endpackage

// File: rtl/ahb_lite_sram.sv
// DEPTH x 32 RAM: byte-enable synchronous write port, asynchronous read port.
// Ports: clk, we[3:0] byte enables, addr word address, wdata, rdata.
module ahb_lite_sram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Per-byte write; untouched lanes keep their contents.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory slave: word-addressed RAM with programmable wait states.
// Ports: HCLK/HRESET (sync, active-high), AHB-Lite address/control inputs,
// HWDATA in, HRDATA/HREADYOUT/HRESP out.
// Build option: AHB_LITE_SLAVE_ERROR_EN enables ERROR responses for
// out-of-range, misaligned or oversize transfers; otherwise addresses wrap.
module ahb_lite_mem_slave
    import ahb_lite_defs::*;
#(
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned WS_W        = 3
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [1:0]  HTRANS,
    input  logic        HMASTLOCK,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int unsigned AW      = $clog2(MEM_DEPTH);
    localparam int unsigned WS_LOAD = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

    logic [ST_W-1:0] state_q, state_d;
    logic [WS_W-1:0] ws_cnt_q, ws_cnt_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic            write_q, write_d;
    logic [2:0]      size_q, size_d;
    logic            ready_q, ready_d;
    logic            accept;
    logic            illegal;
    logic [3:0]      ram_we;
    logic [31:0]     ram_rdata;
    logic            unused_inputs;

    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], HADDR[31:AW+2]};
    assign accept = HSEL & HREADY & HTRANS[1];

`ifdef AHB_LITE_SLAVE_ERROR_EN
    logic resp_q, resp_d;
    assign illegal = (|HADDR[31:AW+2])
                   | ((HSIZE == HSIZE_HALF) & HADDR[0])
                   | ((HSIZE == HSIZE_WORD) & (|HADDR[1:0]))
                   | (HSIZE > 3'(HSIZE_WORD));
`else
    assign illegal = 1'b0;
`endif

    // Next-state, wait counter and address-phase capture.
    always_comb begin
        state_d  = state_q;
        ws_cnt_d = ws_cnt_q;
        addr_d   = addr_q;
        write_d  = write_q;
        size_d   = size_q;
        case (state_q)
            ST_WAIT: begin
                if (ws_cnt_q == '0) state_d = ST_DONE;
                else                ws_cnt_d = ws_cnt_q - WS_W'(1);
            end
`ifdef AHB_LITE_SLAVE_ERROR_EN
            ST_ERR1: state_d = ST_ERR2;
`endif
            default: state_d = ST_IDLE;
        endcase
        // Only ready-high states can see an accept (pipelined next address phase).
        if (accept && (state_q != ST_WAIT)
`ifdef AHB_LITE_SLAVE_ERROR_EN
            && (state_q != ST_ERR1)
`endif
           ) begin
            addr_d  = HADDR[AW+1:0];
            write_d = HWRITE;
            size_d  = HSIZE;
            if (illegal) begin
`ifdef AHB_LITE_SLAVE_ERROR_EN
                state_d = ST_ERR1;
`endif
            end else if (WAIT_STATES > 0) begin
                state_d  = ST_WAIT;
                ws_cnt_d = WS_W'(WS_LOAD);
            end else begin
                state_d = ST_DONE;
            end
        end
        ready_d = (state_d != ST_WAIT);
`ifdef AHB_LITE_SLAVE_ERROR_EN
        if (state_d == ST_ERR1) ready_d = 1'b0;
        resp_d = (state_d == ST_ERR1) || (state_d == ST_ERR2);
`endif
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= ST_IDLE;
            ws_cnt_q <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 3'b000;
            ready_q  <= 1'b1;
`ifdef AHB_LITE_SLAVE_ERROR_EN
            resp_q   <= HRESP_OKAY;
`endif
        end else begin
            state_q  <= state_d;
            ws_cnt_q <= ws_cnt_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            size_q   <= size_d;
            ready_q  <= ready_d;
`ifdef AHB_LITE_SLAVE_ERROR_EN
            resp_q   <= resp_d;
`endif
        end
    end

    // Write commits on the edge closing DONE; a reset on that edge drops it.
    assign ram_we = (state_q == ST_DONE && write_q == HWRITE_WRITE && !HRESET)
                  ? lane_mask(size_q, addr_q[1:0]) : 4'b0000;

    ahb_lite_sram #(.DEPTH(MEM_DEPTH), .AW(AW)) u_sram (
        .clk   (HCLK),
        .we    (ram_we),
        .addr  (addr_q[AW+1:2]),
        .wdata (HWDATA),
        .rdata (ram_rdata)
    );

    assign HRDATA    = (state_q == ST_DONE && write_q == HWRITE_READ) ? ram_rdata : 32'h0;
    assign HREADYOUT = ready_q;
`ifdef AHB_LITE_SLAVE_ERROR_EN
    assign HRESP     = resp_q;
`else
    assign HRESP     = HRESP_OKAY;
`endif

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Directed bench: two slaves (0 and 3 wait states) on a shared master bus,
// each with its own HSEL and HREADY looped from its own HREADYOUT.
module tb_ahb_lite_mem_slave;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel0, hsel3;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hwdata;
    wire  [31:0] hrdata0, hrdata3;
    wire         hreadyout0, hreadyout3, hresp0, hresp3;

    int vec  = 0;
    int errs = 0;

    always #5 hclk = ~hclk;

    ahb_lite_mem_slave #(.MEM_DEPTH(1024), .WAIT_STATES(0), .WS_W(3)) u_ws0 (
        .HCLK(hclk), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
        .HMASTLOCK(hmastlock), .HREADY(hreadyout0), .HWDATA(hwdata),
        .HRDATA(hrdata0), .HREADYOUT(hreadyout0), .HRESP(hresp0));

    ahb_lite_mem_slave #(.MEM_DEPTH(1024), .WAIT_STATES(3), .WS_W(3)) u_ws3 (
        .HCLK(hclk), .HRESET(hreset), .HSEL(hsel3), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
        .HMASTLOCK(hmastlock), .HREADY(hreadyout3), .HWDATA(hwdata),
        .HRDATA(hrdata3), .HREADYOUT(hreadyout3), .HRESP(hresp3));

    function automatic logic cur_ready(input int which);
        return (which == 0) ? hreadyout0 : hreadyout3;
    endfunction
    function automatic logic cur_resp(input int which);
        return (which == 0) ? hresp0 : hresp3;
    endfunction
    function automatic logic [31:0] cur_rdata(input int which);
        return (which == 0) ? hrdata0 : hrdata3;
    endfunction

    // One single transfer followed by an idle bus; waits = -1 on timeout.
    task automatic xfer(input int which, input logic wr, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int waits,
                        output logic resp, output logic resp_first);
        @(negedge hclk);
        hsel0 = (which == 0); hsel3 = (which != 0);
        htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
        @(posedge hclk);
        @(negedge hclk);
        hsel0 = 1'b0; hsel3 = 1'b0; htrans = 2'b00; hwdata = wdata;
        waits = 0;
        resp_first = cur_resp(which);
        while (cur_ready(which) !== 1'b1 && waits < 20) begin
            waits++;
            @(negedge hclk);
        end
        if (waits >= 20) waits = -1;
        rdata = cur_rdata(which);
        resp  = cur_resp(which);
    endtask

    task automatic test_reset;
        hreset = 1'b1;
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        vec++; if (hreadyout0 !== 1'b1) begin errs++; $display("FAIL rst_ready0: got %b want 1", hreadyout0); end
        vec++; if (hreadyout3 !== 1'b1) begin errs++; $display("FAIL rst_ready3: got %b want 1", hreadyout3); end
        vec++; if (hresp0 !== 1'b0) begin errs++; $display("FAIL rst_resp0: got %b want 0", hresp0); end
        vec++; if (hrdata3 !== 32'h0) begin errs++; $display("FAIL rst_rdata3: got %h want 0", hrdata3); end
        hreset = 1'b0;
        @(negedge hclk);
        vec++; if (hrdata0 !== 32'h0) begin errs++; $display("FAIL idle_rdata0: got %h want 0", hrdata0); end
        vec++; if (hreadyout3 !== 1'b1) begin errs++; $display("FAIL idle_ready3: got %b want 1", hreadyout3); end
    endtask

    task automatic test_word_rw;
        logic [31:0] rd; int w; logic r, rf;
        xfer(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, w, r, rf);
        vec++; if (w !== 0 || r !== 1'b0) begin errs++; $display("FAIL wr_ws0: waits %0d resp %b want 0 0", w, r); end
        xfer(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, w, r, rf);
        vec++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL rd_word: got %h want deadbeef", rd); end
        vec++; if (w !== 0 || r !== 1'b0) begin errs++; $display("FAIL rd_ws0: waits %0d resp %b want 0 0", w, r); end
    endtask

    task automatic test_lanes;
        logic [31:0] rd; int w; logic r, rf;
        xfer(0, 1'b1, 3'b010, 32'h20, 32'h11223344, rd, w, r, rf);
        xfer(0, 1'b1, 3'b000, 32'h22, 32'h00AA0000, rd, w, r, rf);
        xfer(0, 1'b0, 3'b010, 32'h20, 32'h0, rd, w, r, rf);
        vec++; if (rd !== 32'h11AA3344) begin errs++; $display("FAIL byte_lane2: got %h want 11aa3344", rd); end
        xfer(0, 1'b1, 3'b010, 32'h24, 32'h01020304, rd, w, r, rf);
        xfer(0, 1'b1, 3'b001, 32'h26, 32'hBEEF5555, rd, w, r, rf);
        xfer(0, 1'b0, 3'b010, 32'h24, 32'h0, rd, w, r, rf);
        vec++; if (rd !== 32'hBEEF0304) begin errs++; $display("FAIL half_upper: got %h want beef0304", rd); end
    endtask

    task automatic test_wait_states;
        logic [31:0] rd; int w; logic r, rf;
        xfer(3, 1'b1, 3'b010, 32'h0, 32'hCAFEF00D, rd, w, r, rf);
        vec++; if (w !== 3) begin errs++; $display("FAIL ws3_write_waits: got %0d want 3", w); end
        xfer(3, 1'b0, 3'b010, 32'h0, 32'h0, rd, w, r, rf);
        vec++; if (w !== 3) begin errs++; $display("FAIL ws3_read_waits: got %0d want 3", w); end
        vec++; if (rd !== 32'hCAFEF00D || r !== 1'b0) begin errs++; $display("FAIL ws3_read: got %h/%b want cafef00d/0", rd, r); end
    endtask

    task automatic test_back_to_back;
        @(negedge hclk);
        hsel0 = 1'b1; htrans = 2'b10; haddr = 32'h40; hwrite = 1'b1; hsize = 3'b010;
        @(posedge hclk);
        @(negedge hclk);
        hwdata = 32'h5; haddr = 32'h40; hwrite = 1'b0;
        vec++; if (hreadyout0 !== 1'b1) begin errs++; $display("FAIL b2b_wr_ready: got %b want 1", hreadyout0); end
        @(posedge hclk);
        @(negedge hclk);
        hsel0 = 1'b0; htrans = 2'b00;
        vec++; if (hrdata0 !== 32'h5 || hreadyout0 !== 1'b1) begin errs++; $display("FAIL b2b_read: got %h/%b want 00000005/1", hrdata0, hreadyout0); end
        @(negedge hclk);
        vec++; if (hrdata0 !== 32'h0) begin errs++; $display("FAIL b2b_after: got %h want 0", hrdata0); end
    endtask

`ifdef AHB_LITE_SLAVE_ERROR_EN
    task automatic test_error;
        logic [31:0] rd; int w; logic r, rf;
        xfer(0, 1'b0, 3'b010, 32'h1000, 32'h0, rd, w, r, rf);
        vec++; if (w !== 1 || rf !== 1'b1) begin errs++; $display("FAIL err1: waits %0d resp %b want 1 1", w, rf); end
        vec++; if (r !== 1'b1 || rd !== 32'h0) begin errs++; $display("FAIL err2: resp %b rdata %h want 1 0", r, rd); end
        xfer(0, 1'b1, 3'b001, 32'h11, 32'hFFFFFFFF, rd, w, r, rf);
        vec++; if (r !== 1'b1) begin errs++; $display("FAIL err_misalign: resp %b want 1", r); end
        xfer(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, w, r, rf);
        vec++; if (rd !== 32'hDEADBEEF || r !== 1'b0) begin errs++; $display("FAIL err_nowrite: got %h/%b want deadbeef/0", rd, r); end
    endtask
`else
    task automatic test_wrap;
        logic [31:0] rd; int w; logic r, rf;
        xfer(0, 1'b1, 3'b010, 32'h1000, 32'h12345678, rd, w, r, rf);
        xfer(0, 1'b0, 3'b010, 32'h0, 32'h0, rd, w, r, rf);
        vec++; if (rd !== 32'h12345678 || r !== 1'b0) begin errs++; $display("FAIL wrap: got %h/%b want 12345678/0", rd, r); end
        xfer(0, 1'b0, 3'b010, 32'h13, 32'h0, rd, w, r, rf);
        vec++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL misalign_word: got %h want deadbeef", rd); end
        xfer(0, 1'b0, 3'b111, 32'h10, 32'h0, rd, w, r, rf);
        vec++; if (rd !== 32'hDEADBEEF || r !== 1'b0) begin errs++; $display("FAIL oversize: got %h/%b want deadbeef/0", rd, r); end
    endtask
`endif

    task automatic test_reset_mid_write;
        logic [31:0] rd; int w; logic r, rf;
        @(negedge hclk);
        hsel3 = 1'b1; htrans = 2'b10; haddr = 32'h0; hwrite = 1'b1; hsize = 3'b010;
        @(posedge hclk);
        @(negedge hclk);
        hsel3 = 1'b0; htrans = 2'b00; hwdata = 32'hFFFFFFFF;
        vec++; if (hreadyout3 !== 1'b0) begin errs++; $display("FAIL mid_wait: got %b want 0", hreadyout3); end
        hreset = 1'b1;
        @(posedge hclk);
        @(negedge hclk);
        hreset = 1'b0;
        vec++; if (hreadyout3 !== 1'b1 || hresp3 !== 1'b0) begin errs++; $display("FAIL mid_rst: got %b/%b want 1/0", hreadyout3, hresp3); end
        xfer(3, 1'b0, 3'b010, 32'h0, 32'h0, rd, w, r, rf);
        vec++; if (rd !== 32'hCAFEF00D) begin errs++; $display("FAIL mid_nocommit: got %h want cafef00d", rd); end
    endtask

    initial begin
        hreset = 1'b1; hsel0 = 1'b0; hsel3 = 1'b0; haddr = 32'h0; hwrite = 1'b0;
        hsize = 3'b010; hburst = 3'b000; hprot = 4'b0011; htrans = 2'b00;
        hmastlock = 1'b0; hwdata = 32'h0;
        test_reset;
        test_word_rw;
        test_lanes;
        test_wait_states;
        test_back_to_back;
`ifdef AHB_LITE_SLAVE_ERROR_EN
        test_error;
`else
        test_wrap;
`endif
        test_reset_mid_write;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
